// File: rtl/aes_ark_pipe.sv
// -----------------------------------------------------------------------------
// aes_ark_pipe
//   Registered AddRoundKey stage with an internal round-key store.
//
//   A state beat is accepted on in_valid & in_ready. In the same cycle, the
//   stage looks up the round key selected by in_rnd, XORs it into the beat and
//   writes the result into a 2-entry in-order output buffer. The result appears
//   on out_* one cycle after acceptance. A beat that selects an out-of-range or
//   unloaded key passes through without the XOR and is flagged with out_err.
//   Bypass beats always pass through unmodified and never set out_err.
//
// Parameters
//   DATA_W    state/key width in bits (multiple of 8)
//   NUM_KEYS  number of round-key entries
//   IDX_W     width of the round index fields (derived from NUM_KEYS)
//
// Ports
//   CLK, rst_n               clock (rising edge), async active-low reset
//   key_wr_en/idx/data       round-key write port
//   key_clr                  invalidate all keys (start of a new key schedule)
//   keys_loaded              every key entry holds a valid key
//   in_valid/ready/data/rnd/bypass   input beat handshake and payload
//   out_valid/ready/data/rnd/err     output beat handshake and payload
// -----------------------------------------------------------------------------
module aes_ark_pipe #(
  parameter  int DATA_W   = 128,
  parameter  int NUM_KEYS = 11,
  localparam int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clr,
  output logic              keys_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_rnd,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_rnd,
  output logic              out_err
);

  // One extra bit so that NUM_KEYS itself is representable for range checks.
  localparam logic [IDX_W:0] NUM_KEYS_W = NUM_KEYS[IDX_W:0];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  rnd;
    logic              err;
  } beat_t;

  // ---------------------------------------------------------------------------
  // Round-key store
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]   key_mem [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_vld_q, key_vld_d;
  logic                wr_hit;

  assign wr_hit = key_wr_en && ({1'b0, key_wr_idx} < NUM_KEYS_W);

  // Clear is applied first so a same-cycle write leaves its entry valid.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that skips an assignment would otherwise infer a latch.
    key_vld_d = key_vld_q;
    if (key_clr) key_vld_d = '0;
    if (wr_hit)  key_vld_d[key_wr_idx] = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching real hardware.
    if (!rst_n) key_vld_q <= '0;
    else        key_vld_q <= key_vld_d;
  end

  // NOTE: the key array has no reset; its contents are meaningless until the
  // matching valid bit is set, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_hit) key_mem[key_wr_idx] <= key_wr_data;
  end

  assign keys_loaded = &key_vld_q;

  // ---------------------------------------------------------------------------
  // Lookup and XOR in the acceptance cycle. key_mem is read before the edge,
  // so a write to the same entry in this cycle is not seen by this beat.
  // ---------------------------------------------------------------------------
  logic              rnd_in_range;
  logic              key_ok;
  logic [DATA_W-1:0] key_sel;
  beat_t             new_beat;

  assign rnd_in_range = ({1'b0, in_rnd} < NUM_KEYS_W);
  assign key_sel      = rnd_in_range ? key_mem[in_rnd] : '0;
  assign key_ok       = rnd_in_range && key_vld_q[in_rnd];

  always_comb begin
    new_beat.rnd  = in_rnd;
    new_beat.err  = !in_bypass && !key_ok;
    new_beat.data = (in_bypass || !key_ok) ? in_data : (in_data ^ key_sel);
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO. in_ready depends only on the registered count, so
  // there is no combinational path from out_ready to in_ready.
  // ---------------------------------------------------------------------------
  beat_t      buf_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= new_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry is held in registers, so out_* stay stable while stalled.
  assign out_data = buf_q[rd_ptr_q].data;
  assign out_rnd  = buf_q[rd_ptr_q].rnd;
  assign out_err  = buf_q[rd_ptr_q].err;

endmodule

// File: tb/tb_aes_ark_pipe.sv
// -----------------------------------------------------------------------------
// tb_aes_ark_pipe
//   Self-checking bench for aes_ark_pipe. A behavioural model (key array,
//   valid flags and a queue of expected output beats) predicts every output;
//   directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_aes_ark_pipe;

  localparam int DATA_W   = 128;
  localparam int NUM_KEYS = 11;
  localparam int IDX_W    = 4;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_idx;
  logic [DATA_W-1:0] key_wr_data;
  logic              key_clr;
  logic              keys_loaded;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_rnd;
  logic              in_bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_rnd;
  logic              out_err;

  aes_ark_pipe #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_clr     (key_clr),
    .keys_loaded (keys_loaded),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rnd      (in_rnd),
    .in_bypass   (in_bypass),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rnd     (out_rnd),
    .out_err     (out_err)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  rnd;
    logic              err;
  } exp_t;

  logic [DATA_W-1:0] m_key [16];
  bit                m_vld [16];
  exp_t              m_q[$];

  function automatic bit m_loaded();
    for (int i = 0; i < NUM_KEYS; i++) if (!m_vld[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t m_predict(input logic [DATA_W-1:0] d,
                                     input logic [IDX_W-1:0] r, input logic byp);
    exp_t e;
    e.rnd = r;
    if (byp) begin
      e.data = d; e.err = 1'b0;
    end else if (int'(r) >= NUM_KEYS || !m_vld[r]) begin
      e.data = d; e.err = 1'b1;
    end else begin
      e.data = d ^ m_key[r]; e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic m_flush();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model with the
  // inputs the DUT will sample at the next rising edge, then return #1 after it.
  task automatic step();
    exp_t e;
    bit   acc;
    @(negedge CLK);
    check("in_ready",    in_ready,    m_q.size() < 2);
    check("out_valid",   out_valid,   m_q.size() > 0);
    check("keys_loaded", keys_loaded, m_loaded());
    if (m_q.size() > 0) begin
      check("out_data", out_data, m_q[0].data);
      check("out_rnd",  out_rnd,  m_q[0].rnd);
      check("out_err",  out_err,  m_q[0].err);
    end
    acc = in_valid && (m_q.size() < 2);
    if (acc) e = m_predict(in_data, in_rnd, in_bypass);
    if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (acc) m_q.push_back(e);
    if (key_clr) for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    if (key_wr_en && int'(key_wr_idx) < NUM_KEYS) begin
      m_key[key_wr_idx] = key_wr_data;
      m_vld[key_wr_idx] = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    key_wr_en = 1'b0;
    key_clr   = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_all_keys();
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_wr_en   = 1'b1;
      key_wr_idx  = IDX_W'(i);
      key_wr_data = rand_data();
      step();
    end
    key_wr_en = 1'b0;
  endtask

  logic [DATA_W-1:0] d_a, d_b, old_k2;

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    key_wr_idx = '0; key_wr_data = '0; in_data = '0; in_rnd = '0;
    idle();
    m_flush();
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_out_valid",   out_valid,   1'b0);
    check("rst_in_ready",    in_ready,    1'b1);
    check("rst_keys_loaded", keys_loaded, 1'b0);
    check("rst_out_data",    out_data,    '0);
    check("rst_out_rnd",     out_rnd,     '0);
    check("rst_out_err",     out_err,     1'b0);

    // 1. FIPS-197 Appendix B round 0
    key_wr_en = 1'b1; key_wr_idx = 4'd0;
    key_wr_data = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    step();
    key_wr_en = 1'b0;
    in_valid = 1'b1; in_rnd = 4'd0; in_data = 128'h3243f6a8885a308d313198a2e0370734;
    step();
    idle();
    check("fips_valid", out_valid, 1'b1);
    check("fips_data",  out_data,  128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("fips_err",   out_err,   1'b0);
    step();

    // 2. Full key load, then clear
    for (int i = 0; i < NUM_KEYS; i++) begin
      key_wr_en = 1'b1; key_wr_idx = IDX_W'(i); key_wr_data = rand_data();
      step();
      if (i == NUM_KEYS - 2) check("loaded_after_10", keys_loaded, 1'b0);
    end
    key_wr_en = 1'b0;
    check("loaded_after_11", keys_loaded, 1'b1);
    key_clr = 1'b1; step(); key_clr = 1'b0;
    check("loaded_after_clr", keys_loaded, 1'b0);
    d_a = rand_data();
    in_valid = 1'b1; in_rnd = 4'd3; in_data = d_a;
    step(); idle();
    check("clr_err",  out_err,  1'b1);
    check("clr_data", out_data, d_a);
    step();

    // 3. Out-of-range round index, with and without bypass
    load_all_keys();
    in_valid = 1'b1; in_rnd = 4'd11; in_data = d_a;
    step(); idle();
    check("oor_err", out_err, 1'b1);
    in_valid = 1'b1; in_bypass = 1'b1;
    step(); idle();
    check("oor_bypass_err",  out_err,  1'b0);
    check("oor_bypass_data", out_data, d_a);
    step();

    // 4. Backpressure: 3 beats offered, only 2 taken, then drained in order
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rnd = IDX_W'(i + 4); in_data = rand_data();
      step();
    end
    check("bp_in_ready", in_ready, 1'b0);
    idle();
    out_ready = 1'b1;
    repeat (3) step();
    check("bp_drained", out_valid, 1'b0);

    // 5. Same-cycle key write does not affect the beat being accepted
    old_k2 = m_key[2];
    d_a = rand_data(); d_b = rand_data();
    in_valid = 1'b1; in_rnd = 4'd2; in_data = d_a;
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = '1;
    step();
    key_wr_en = 1'b0; in_data = d_b;
    check("wr_same_cycle_old_key", out_data, d_a ^ old_k2);
    step(); idle();
    check("wr_next_beat_new_key", out_data, ~d_b);
    step();

    // 6. Asynchronous reset with two buffered beats
    out_ready = 1'b0;
    in_valid = 1'b1; in_rnd = 4'd1;
    repeat (2) begin in_data = rand_data(); step(); end
    idle();
    check("pre_rst_full", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready",  in_ready,  1'b1);
    m_flush();
    @(posedge CLK);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_keys_loaded", keys_loaded, 1'b0);

    // Randomized phase
    load_all_keys();
    for (int c = 0; c < 2000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = rand_data();
      in_rnd      = IDX_W'($urandom_range(0, 12));
      in_bypass   = ($urandom_range(0, 7) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      key_wr_en   = ($urandom_range(0, 5) == 0);
      key_wr_idx  = IDX_W'($urandom_range(0, 15));
      key_wr_data = rand_data();
      key_clr     = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    out_ready = 1'b1;
    repeat (4) step();
    check("final_drained", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
